// File: rtl/wb_data_mem.sv
// Single-outstanding Wishbone memory responder: funct3-style byte/half/word
// accesses, little-endian, fixed accept-to-ack latency, err on illegal access.
module wb_data_mem #(
    parameter int    ADDR_WIDTH = 10,
    parameter int    LATENCY    = 1,
    parameter string INIT_FILE  = "mem.hex"
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [2:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_wb_err
);
    // state  | meaning
    // S_IDLE | waiting for i_wb_stb, stall low
    // S_BUSY | request latched, latency countdown running
    // S_ACK  | ack (and err) pulse, read result on o_wb_data
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

    localparam int AW = ADDR_WIDTH + 2;

    logic [31:0]   r_mem [0:(1<<ADDR_WIDTH)-1];
    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic [2:0]    r_sel;

    logic          w_idle, w_accept, w_commit, w_wr_en;
    logic          w_we, w_err;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_data, w_word, w_rdata, w_wdata;
    logic [2:0]    w_sel;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_wmask;
    logic          w_unused_addr;

    assign w_unused_addr = ^i_wb_addr[31:AW];

    // With LATENCY=1 the access completes on the accept edge, so it must see the live inputs.
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && i_wb_stb;
    assign w_we     = w_idle ? i_wb_we              : r_we;
    assign w_addr   = w_idle ? i_wb_addr[AW-1:0]    : r_addr;
    assign w_data   = w_idle ? i_wb_data            : r_data;
    assign w_sel    = w_idle ? i_wb_sel             : r_sel;
    assign w_commit = (w_accept && (LATENCY == 1)) || (r_state == S_BUSY && r_cnt == 4'd1);
    assign w_wr_en  = w_commit && i_reset_n && w_we && !w_err;

    assign w_word = r_mem[w_addr[AW-1:2]];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (w_sel)
            3'b000, 3'b100: w_err = 1'b0;
            3'b001, 3'b101: w_err = w_addr[0];
            3'b010:         w_err = (w_addr[1:0] != 2'b00);
            default:        w_err = 1'b1;
        endcase
        if (w_we && w_sel[2]) w_err = 1'b1;
    end

    always_comb begin
        case (w_sel)
            3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
            3'b010:  w_rdata = w_word;
            3'b100:  w_rdata = {24'h0, w_byte};
            3'b101:  w_rdata = {16'h0, w_half};
            default: w_rdata = 32'h0;
        endcase
    end

    always_comb begin
        case (w_sel[1:0])
            2'b00: begin
                w_wdata = {4{w_data[7:0]}};
                w_wmask = 4'b0001 << w_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{w_data[15:0]}};
                w_wmask = w_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = w_data;
                w_wmask = 4'b1111;
            end
        endcase
    end

    // Memory has no reset so its contents survive i_reset_n.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wmask[i]) r_mem[w_addr[AW-1:2]][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= 32'h0;
            r_sel      <= 3'b000;
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
            o_wb_stall <= 1'b0;
            o_wb_data  <= 32'h0;
        end else begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= 32'h0;
            if (w_commit) begin
                o_wb_ack  <= 1'b1;
                o_wb_err  <= w_err;
                o_wb_data <= (w_we || w_err) ? 32'h0 : w_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_wb_stb) begin
                        r_we       <= i_wb_we;
                        r_addr     <= i_wb_addr[AW-1:0];
                        r_data     <= i_wb_data;
                        r_sel      <= i_wb_sel;
                        o_wb_stall <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state <= S_ACK;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_ACK;
                end
                S_ACK: begin
                    o_wb_stall <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
